// File: rtl/fp_add_pkg.sv
// Shared types and constants for the floating-point adder result path.
package fp_add_pkg;

  localparam int FP_W   = 32;
  localparam int FLAG_W = 4;

  // Bit positions inside the adder flag vector {ERR,NEG_INF,INF,NAN}
  localparam int FLAG_NAN     = 0;
  localparam int FLAG_INF     = 1;
  localparam int FLAG_NEG_INF = 2;
  localparam int FLAG_ERR     = 3;

  typedef struct packed {
    logic [FLAG_W-1:0] flags;
    logic [FP_W-1:0]   result;
  } fp_res_t;

  localparam int RES_W = $bits(fp_res_t);

endpackage

// File: rtl/fp_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Head data is read combinationally from storage; a write into an empty
// FIFO becomes visible the following cycle. Pops on an empty FIFO are
// ignored and pushes on a full FIFO without a pop are dropped.
module fp_sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  // Storage, power-of-two wrapping pointers and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp_add_result_collector.sv
// Collects floating-point adder results a fixed latency after each launch
// and queues them for a valid/ready consumer. Launches are throttled by
// credits so that every in-flight result already owns a FIFO slot.
// Optional feature macro: FP_EXC_COUNT_EN adds four saturating per-flag
// exception counters (nan_cnt, inf_cnt, ninf_cnt, err_cnt).
module fp_add_result_collector
  import fp_add_pkg::*;
#(
  parameter int ADDER_LAT = 2,
  parameter int DEPTH     = 4
`ifdef FP_EXC_COUNT_EN
  , parameter int CNT_W   = 16
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    launch_valid,
  output logic                    launch_ready,
  input  logic [FP_W-1:0]         add_result,
  input  logic [FLAG_W-1:0]       add_flags,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FP_W-1:0]         out_result,
  output logic [FLAG_W-1:0]       out_flags,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [FLAG_W-1:0]       exc_sticky,
  input  logic                    clr_sticky
`ifdef FP_EXC_COUNT_EN
  , output logic [CNT_W-1:0]      nan_cnt
  , output logic [CNT_W-1:0]      inf_cnt
  , output logic [CNT_W-1:0]      ninf_cnt
  , output logic [CNT_W-1:0]      err_cnt
`endif
);

  // Wide enough for DEPTH plus every pipe slot without wrapping
  localparam int CW = $clog2(DEPTH + ADDER_LAT + 1) + 1;

  logic [ADDER_LAT-1:0] vpipe;
  logic                 accept;
  logic                 capture;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FLAG_W-1:0]    cap_flags;
  logic [CW-1:0]        inflight;
  logic [CW-1:0]        credits;
  fp_res_t              wr_res;
  fp_res_t              rd_res;

  assign accept    = launch_valid & launch_ready;
  assign capture   = vpipe[ADDER_LAT-1];
  assign pop       = out_valid & out_ready;
  assign cap_flags = capture ? add_flags : '0;
  assign wr_res    = '{flags: add_flags, result: add_result};

  assign out_valid  = ~fifo_empty;
  assign out_result = rd_res.result;
  assign out_flags  = rd_res.flags;

  fp_sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .wdata (wr_res),
    .pop   (pop),
    .rdata (rd_res),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Latency pipe: one bit per accepted launch, captured when it reaches the end
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= accept;
      for (int i = 1; i < ADDER_LAT; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  // Credits from registered state only, so a pop frees a slot one cycle later
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ADDER_LAT; i++) inflight = inflight + CW'(vpipe[i]);
    credits      = CW'(DEPTH) - CW'(fifo_count) - inflight;
    launch_ready = (credits != '0) & ~rst;
  end

  // Sticky exception summary; a capture in the clearing cycle survives the clear
  always_ff @(posedge clk) begin
    if (rst) exc_sticky <= '0;
    else     exc_sticky <= (clr_sticky ? '0 : exc_sticky) | cap_flags;
  end

  // A capture can only land in a full FIFO if the credit accounting is broken
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(capture && fifo_full && !pop))
        else $error("fp_add_result_collector: capture into full FIFO");
    end
  end

`ifdef FP_EXC_COUNT_EN
  logic [CNT_W-1:0] exc_cnt [FLAG_W];

  // Saturating per-flag counters; clearing restarts at the same-cycle capture
  always_ff @(posedge clk) begin
    for (int i = 0; i < FLAG_W; i++) begin
      if (rst)
        exc_cnt[i] <= '0;
      else if (clr_sticky)
        exc_cnt[i] <= CNT_W'(cap_flags[i]);
      else if (cap_flags[i] && (exc_cnt[i] != '1))
        exc_cnt[i] <= exc_cnt[i] + 1'b1;
    end
  end

  assign nan_cnt  = exc_cnt[FLAG_NAN];
  assign inf_cnt  = exc_cnt[FLAG_INF];
  assign ninf_cnt = exc_cnt[FLAG_NEG_INF];
  assign err_cnt  = exc_cnt[FLAG_ERR];
`endif

endmodule

// File: tb/tb_fp_add_result_collector.sv
// Scoreboard bench for fp_add_result_collector. Define FP_EXC_COUNT_EN to
// also exercise the exception counters (built with CNT_W=2).
module tb_fp_add_result_collector;
  import fp_add_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int QW    = $clog2(DEPTH) + 1;
`ifdef FP_EXC_COUNT_EN
  localparam int CNT_W = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          launch_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          clr_sticky = 1'b0;
  logic [31:0]   add_result = '0;
  logic [3:0]    add_flags = '0;
  logic          launch_ready;
  logic          out_valid;
  logic [31:0]   out_result;
  logic [3:0]    out_flags;
  logic [QW-1:0] fifo_count;
  logic [3:0]    exc_sticky;
`ifdef FP_EXC_COUNT_EN
  logic [CNT_W-1:0] nan_cnt, inf_cnt, ninf_cnt, err_cnt;
  logic [CNT_W-1:0] dut_cnt [4];
  assign dut_cnt[0] = nan_cnt;
  assign dut_cnt[1] = inf_cnt;
  assign dut_cnt[2] = ninf_cnt;
  assign dut_cnt[3] = err_cnt;
`endif

  // Payload the adder will produce for the launch being presented
  logic [31:0] stim_res = '0;
  logic [3:0]  stim_flags = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          launch_edge;
    logic [31:0] res;
    logic [3:0]  flags;
  } exp_t;

  exp_t        sb[$];
  logic [35:0] adder_out [int];
  logic [3:0]  m_sticky = '0;
  int          m_cnt [4];

  fp_add_result_collector #(
    .ADDER_LAT (LAT),
    .DEPTH     (DEPTH)
`ifdef FP_EXC_COUNT_EN
    , .CNT_W   (CNT_W)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .launch_valid (launch_valid),
    .launch_ready (launch_ready),
    .add_result   (add_result),
    .add_flags    (add_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .fifo_count   (fifo_count),
    .exc_sticky   (exc_sticky),
    .clr_sticky   (clr_sticky)
`ifdef FP_EXC_COUNT_EN
    , .nan_cnt    (nan_cnt)
    , .inf_cnt    (inf_cnt)
    , .ninf_cnt   (ninf_cnt)
    , .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Adder model: a launch's payload appears LAT cycles later; otherwise junk
  always @(posedge clk) begin
    #1;
    if (adder_out.exists(cyc + 1)) begin
      {add_flags, add_result} = adder_out[cyc + 1];
      adder_out.delete(cyc + 1);
    end else begin
      add_result = $urandom;
      add_flags  = 4'($urandom);
    end
  end

  // Monitor: compares DUT against the transaction-level model every cycle
  always @(negedge clk) begin : mon
    int         exp_cnt;
    logic       exp_valid;
    logic       exp_ready;
    logic       capt;
    logic [3:0] capf;
    exp_cnt = 0;
    capt    = 1'b0;
    capf    = '0;
    foreach (sb[i]) begin
      if (sb[i].launch_edge + LAT <= cyc) exp_cnt++;
      if (sb[i].launch_edge + LAT == cyc + 1) begin
        capt = 1'b1;
        capf = sb[i].flags;
      end
    end
    exp_valid = (exp_cnt > 0);
    exp_ready = !rst && (sb.size() < DEPTH);
    chk("launch_ready", launch_ready, exp_ready);
    chk("out_valid", out_valid, exp_valid);
    chk("fifo_count", fifo_count, exp_cnt);
    chk("exc_sticky", exc_sticky, m_sticky);
`ifdef FP_EXC_COUNT_EN
    for (int f = 0; f < 4; f++) chk($sformatf("exc_cnt%0d", f), dut_cnt[f], m_cnt[f]);
`endif
    if (exp_valid) begin
      chk("out_result", out_result, sb[0].res);
      chk("out_flags", out_flags, sb[0].flags);
    end
    if (rst) begin
      sb.delete();
      m_sticky = '0;
      for (int f = 0; f < 4; f++) m_cnt[f] = 0;
    end else begin
      m_sticky = (clr_sticky ? 4'b0 : m_sticky) | capf;
`ifdef FP_EXC_COUNT_EN
      for (int f = 0; f < 4; f++) begin
        if (clr_sticky)
          m_cnt[f] = (capt && capf[f]) ? 1 : 0;
        else if (capt && capf[f] && m_cnt[f] < (1 << CNT_W) - 1)
          m_cnt[f] = m_cnt[f] + 1;
      end
`endif
      if (exp_valid && out_ready) void'(sb.pop_front());
      if (launch_valid && exp_ready) begin
        sb.push_back('{cyc + 1, stim_res, stim_flags});
        adder_out[cyc + 1 + LAT] = {stim_flags, stim_res};
      end
    end
  end

  initial begin : stim
    int got;
    for (int f = 0; f < 4; f++) m_cnt[f] = 0;

    // Reset state
    step(3);
    @(negedge clk);
    chk("rst_launch_ready", launch_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_exc_sticky", exc_sticky, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", launch_ready, 1);
    step();

    // Single launch: result visible exactly LAT+1 cycles later
    stim_res = 32'h4729DF1B;
    stim_flags = 4'b0000;
    launch_valid = 1'b1;
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge clk);
      chk($sformatf("t1_valid_c%0d", k), out_valid, (k == LAT + 1));
      step();
      launch_valid = 1'b0;
    end
    chk("t1_result", out_result, 32'h4729DF1B);
    chk("t1_flags", out_flags, 4'b0000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // INF then NaN/ERR: ordered entries and OR'd sticky summary
    stim_res = 32'h7F800000; stim_flags = 4'b0010; launch_valid = 1'b1;
    step();
    stim_res = 32'h7FC00000; stim_flags = 4'b1001;
    step();
    launch_valid = 1'b0;
    step(LAT + 1);
    @(negedge clk);
    chk("t2_sticky", exc_sticky, 4'b1011);
    chk("t2_count", fifo_count, 2);
    chk("t2_head", out_result, 32'h7F800000);
    out_ready = 1'b1;
    step(2);
    out_ready = 1'b0;
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;

    // Back-pressure: exactly DEPTH launches accepted, no loss
    got = 0;
    launch_valid = 1'b1;
    for (int k = 0; k < DEPTH + LAT + 4; k++) begin
      stim_res = $urandom;
      stim_flags = 4'($urandom);
      @(negedge clk);
      if (launch_ready) got++;
      step();
    end
    launch_valid = 1'b0;
    @(negedge clk);
    chk("t3_accepted", got, DEPTH);
    chk("t3_full_count", fifo_count, DEPTH);
    chk("t3_ready_low", launch_ready, 0);

    // Drain while launching every cycle: push and pop overlap
    step();
    out_ready = 1'b1;
    launch_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      stim_res = $urandom;
      stim_flags = 4'($urandom);
      step();
    end
    launch_valid = 1'b0;
    step(LAT + DEPTH + 2);
    @(negedge clk);
    chk("t4_drained", sb.size(), 0);
    out_ready = 1'b0;
    step();

    // Reset with one stored entry and two launches in flight
    stim_res = 32'h11111111; stim_flags = 4'b0100; launch_valid = 1'b1;
    step();
    launch_valid = 1'b0;
    step(LAT + 1);
    stim_res = 32'h22222222; stim_flags = 4'b0001; launch_valid = 1'b1;
    step();
    stim_res = 32'h33333333; stim_flags = 4'b1000;
    step();
    launch_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_valid", out_valid, 0);
    chk("t5_count", fifo_count, 0);
    chk("t5_result", out_result, 0);
    chk("t5_sticky", exc_sticky, 0);
    out_ready = 1'b1;
    for (int k = 0; k < LAT + 4; k++) begin
      step();
      @(negedge clk);
      chk($sformatf("t5_quiet_c%0d", k), out_valid, 0);
    end
    step();

`ifdef FP_EXC_COUNT_EN
    // Counter saturation and clear-with-concurrent-increment
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    for (int k = 0; k < 5; k++) begin
      stim_res = $urandom; stim_flags = 4'b1000; launch_valid = 1'b1;
      step();
      launch_valid = 1'b0;
      step(LAT + 1);
    end
    @(negedge clk);
    chk("t6_err_sat", err_cnt, 3);
    step();
    stim_res = $urandom; stim_flags = 4'b1000; launch_valid = 1'b1;
    step();
    launch_valid = 1'b0;
    step(LAT - 1);
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    @(negedge clk);
    chk("t6_err_clr", err_cnt, 1);
    chk("t6_sticky_err", exc_sticky[3], 1);
    step(LAT + 2);
`endif

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      launch_valid = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 9) < 7);
      clr_sticky   = ($urandom_range(0, 15) == 0);
      stim_res     = $urandom;
      stim_flags   = 4'($urandom);
      step();
    end
    launch_valid = 1'b0;
    clr_sticky = 1'b0;
    out_ready = 1'b1;
    step(LAT + DEPTH + 3);
    @(negedge clk);
    chk("final_drained", sb.size(), 0);
    chk("final_count", fifo_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
